// File: rtl/instr_encoder.sv
// Packs ARM-subset instruction fields into 32-bit words and streams them
// into instruction memory, rejecting encodings the datapath cannot decode.
module instr_encoder #(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        cond,
  input  logic [1:0]        op,
  input  logic [5:0]        funct,
  input  logic [3:0]        rn,
  input  logic [3:0]        rd,
  input  logic [11:0]       src2,
  input  logic [23:0]       imm24,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W:0]   r_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_err;

  logic              w_acc;
  logic              w_bad;
  logic              w_good;
  logic              w_full;
  logic              w_start;
  logic [31:0]       w_word;

  assign in_ready = (r_state == S_RUN) && (r_ptr < LP_DEPTH);
  assign w_acc    = in_valid && in_ready;
  assign w_good   = w_acc && !w_bad;
  assign w_full   = w_good && ((r_ptr + 1'b1) == LP_DEPTH);
  assign w_start  = start &&
                    ((r_state == S_IDLE) || (r_state == S_DONE));

  // Only ADD/SUB/AND/ORR are decoded; branches must carry funct[5]=1.
  always_comb begin
    w_bad  = 1'b0;
    w_word = {cond, op, funct, rn, rd, src2};
    unique case (op)
      2'b00: begin
        w_bad = !((funct[4:1] == 4'b0100) ||
                  (funct[4:1] == 4'b0010) ||
                  (funct[4:1] == 4'b0000) ||
                  (funct[4:1] == 4'b1100));
      end
      2'b01: w_bad = 1'b0;
      2'b10: begin
        w_bad  = !funct[5];
        w_word = {cond, 2'b10, funct[5:4], imm24};
      end
      2'b11: w_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_acc && (in_last || w_full)) w_next = S_DRAIN;
      S_DRAIN: w_next = S_DONE;
      S_DONE:  if (start) w_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_count <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_we    <= w_good;
      if (w_good) begin
        r_addr  <= r_ptr[ADDR_W-1:0];
        r_wdata <= w_word;
        r_ptr   <= r_ptr + 1'b1;
      end
      if (w_acc && w_bad) r_err <= 1'b1;
      if (r_we && (r_count != LP_DEPTH)) r_count <= r_count + 1'b1;
      if (w_start) begin
        r_ptr   <= '0;
        r_count <= '0;
        r_err   <= 1'b0;
      end
    end
  end

  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign count     = r_count;
  assign err       = r_err;
  assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);

endmodule
